// File: rtl/seq_tx_pkg.sv
// rtl/seq_tx_pkg.sv - state encoding and sync header constants for the 110-link transmitter
package seq_tx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    DATA = 3'd2,
    PAR  = 3'd3,
    GAP  = 3'd4
  } tx_state_t;

  localparam logic [2:0] SYNC_HDR = 3'b110;
  localparam int         HDR_LEN  = 3;

endpackage

// File: rtl/seq_tx_shreg.sv
// rtl/seq_tx_shreg.sv - loadable MSB-first shift register; parity output only with SEQ_TX_PARITY_EN
module seq_tx_shreg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
`ifdef SEQ_TX_PARITY_EN
  output logic              par,
`endif
  output logic              msb
);

  logic [DATA_W-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[DATA_W-2:0], 1'b0};
    end
  end

  assign msb = sr[DATA_W-1];

`ifdef SEQ_TX_PARITY_EN
  // Parity is taken from the word at load time, so shifting never disturbs it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      par <= 1'b0;
    end else if (load) begin
      par <= ^din;
    end
  end
`endif

endmodule

// File: rtl/seq_frame_tx.sv
// rtl/seq_frame_tx.sv - serial 110-sync frame transmitter; SEQ_TX_PARITY_EN adds an even-parity bit
module seq_frame_tx
  import seq_tx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_bit,
  output logic              tx_active,
  output logic              frame_done
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [1:0]       HDR_LAST = 2'(HDR_LEN - 1);
  localparam logic [7:0]       GAP_LAST = 8'(GAP_CYCLES - 1);

  tx_state_t        state;
  tx_state_t        state_nxt;
  logic [1:0]       hdr_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       gap_cnt;
  logic             out_nxt;
  logic             load;
  logic             shift;
  logic             sh_msb;
`ifdef SEQ_TX_PARITY_EN
  logic             sh_par;
`endif

  seq_tx_shreg #(
    .DATA_W (DATA_W)
  ) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (in_data),
`ifdef SEQ_TX_PARITY_EN
    .par   (sh_par),
`endif
    .msb   (sh_msb)
  );

  // out_bit is registered, so it is loaded with the bit belonging to the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      out_bit <= 1'b0;
      hdr_cnt <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      out_bit <= out_nxt;
      hdr_cnt <= (state == HDR) ? hdr_cnt + 2'd1 : 2'd0;
      bit_cnt <= (state == DATA) ? bit_cnt + CNT_W'(1) : '0;
      if (state_nxt == GAP) begin
        gap_cnt <= (state == GAP) ? gap_cnt - 8'd1 : GAP_LAST;
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = HDR;
      HDR:  if (hdr_cnt == HDR_LAST) state_nxt = DATA;
      DATA: begin
        if (bit_cnt == BIT_LAST) begin
`ifdef SEQ_TX_PARITY_EN
          state_nxt = PAR;
`else
          state_nxt = GAP;
`endif
        end
      end
`ifdef SEQ_TX_PARITY_EN
      PAR:  state_nxt = GAP;
`endif
      GAP:  if (gap_cnt == 8'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == IDLE);
    tx_active  = (state == HDR) || (state == DATA) || (state == PAR);
    frame_done = (state == GAP) && (gap_cnt == GAP_LAST);
    load       = 1'b0;
    shift      = 1'b0;
    out_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          out_nxt = SYNC_HDR[2];
        end
      end
      HDR: begin
        case (hdr_cnt)
          2'd0:    out_nxt = SYNC_HDR[1];
          2'd1:    out_nxt = SYNC_HDR[0];
          default: begin
            out_nxt = sh_msb;
            shift   = 1'b1;
          end
        endcase
      end
      DATA: begin
        if (bit_cnt == BIT_LAST) begin
`ifdef SEQ_TX_PARITY_EN
          out_nxt = sh_par;
`else
          out_nxt = 1'b0;
`endif
        end else begin
          out_nxt = sh_msb;
          shift   = 1'b1;
        end
      end
      default: out_nxt = 1'b0;
    endcase
  end

endmodule
